// File: rtl/i2s_tdm_rx.sv
// Master-mode I2S / left-justified / TDM receiver: drives sck/ws, deserialises sdi into a one-deep valid/ready output register
// (sample valid 1 clk after the sck rise of its last captured bit; a sample arriving while the register is held is dropped and flags overrun). Optional peak tracker: I2S_TDM_RX_PEAK_EN.
module i2s_tdm_rx #(
    parameter int SW  = 32,
    parameter int NCH = 8,
    parameter int PW  = 8,
    localparam int CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic [PW-1:0]  sck_prescaler,
    input  logic [5:0]     slot_width,
    input  logic [5:0]     sample_size,
    input  logic [CW:0]    num_slots,
    input  logic [NCH-1:0] ch_en,
    input  logic           sign_extend,
    output logic           sck,
    output logic           ws,
    input  logic           sdi,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_data,
    output logic [CW-1:0]  out_ch,
    output logic           overrun,
    input  logic           ovr_clr
`ifdef I2S_TDM_RX_PEAK_EN
    ,
    output logic [SW-1:0]  peak,
    output logic           peak_valid
`endif
);

    typedef enum logic [1:0] {
        MODE_I2S = 2'b00,
        MODE_LJ  = 2'b01,
        MODE_TDM = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    localparam int          NSL_W   = CW + 1;
    localparam logic [CW:0] NSL_ONE = NSL_W'(1);
    localparam logic [CW:0] NSL_TWO = NSL_W'(2);
    localparam logic [CW:0] NSL_MAX = NSL_W'(NCH);
    localparam logic [5:0]  SW6     = 6'(SW);
    localparam logic [SW-1:0] SW_ONE = SW'(1);

    logic [5:0]  sw_eff;
    logic [5:0]  size_eff;
    logic [CW:0] nsl_eff;

    // Out-of-range configuration is clamped rather than rejected.
    always_comb begin
        sw_eff = slot_width;
        if (slot_width < 6'd2) begin
            sw_eff = 6'd2;
        end else if (slot_width > SW6) begin
            sw_eff = SW6;
        end
        size_eff = sample_size;
        if (sample_size == 6'd0 || sample_size > sw_eff) begin
            size_eff = sw_eff;
        end
        nsl_eff = NSL_TWO;
        if (mode_e'(mode) == MODE_TDM) begin
            nsl_eff = num_slots;
            if (num_slots == '0) begin
                nsl_eff = NSL_ONE;
            end else if (num_slots > NSL_MAX) begin
                nsl_eff = NSL_MAX;
            end
        end
    end

    logic [PW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          ws_q, ws_d;
    logic [5:0]    bit_q, bit_d;
    logic [CW-1:0] slot_q, slot_d;
    logic [SW-2:0] sh_q, sh_d;

    logic          tick, rise, fall;
    logic          last_bit, last_slot;
    logic [5:0]    nxt_bit;
    logic [CW-1:0] nxt_slot;
    logic          ws_nxt;
    logic [SW-1:0] sh_shift, size_mask, msb_sel, cap_dat;
    logic          sgn, cap_fire, new_smp;

    always_comb begin
        tick      = en && (cnt_q == '0);
        rise      = tick && !sck_q;
        fall      = tick && sck_q;
        last_bit  = (bit_q == sw_eff - 6'd1);
        last_slot = ({1'b0, slot_q} == nsl_eff - NSL_ONE);
        nxt_bit   = last_bit ? 6'd0 : bit_q + 6'd1;
        nxt_slot  = slot_q;
        if (last_bit) begin
            nxt_slot = last_slot ? '0 : slot_q + CW'(1);
        end
        // ws is registered on the fall tick with the level for the bit that starts there.
        ws_nxt = 1'b1;
        case (mode_e'(mode))
            MODE_LJ:  ws_nxt = (nxt_slot == CW'(1));
            MODE_TDM: ws_nxt = (nxt_bit == sw_eff - 6'd1) &&
                               ({1'b0, nxt_slot} == nsl_eff - NSL_ONE);
            default:  ws_nxt = (nxt_bit == sw_eff - 6'd1) ? (nxt_slot == '0)
                                                          : (nxt_slot == CW'(1));
        endcase
    end

    always_comb begin
        sh_shift  = {sh_q, sdi};
        size_mask = ~({SW{1'b1}} << size_eff);
        msb_sel   = SW_ONE << (size_eff - 6'd1);
        sgn       = sign_extend && |(sh_shift & msb_sel);
        cap_dat   = sgn ? (sh_shift | ~size_mask) : (sh_shift & size_mask);
        cap_fire  = rise && (bit_q == size_eff - 6'd1);
        new_smp   = cap_fire && ch_en[slot_q];
    end

    always_comb begin
        cnt_d  = cnt_q;
        sck_d  = sck_q;
        ws_d   = ws_q;
        bit_d  = bit_q;
        slot_d = slot_q;
        sh_d   = sh_q;
        if (!en) begin
            // Prescaler count is frozen; everything else returns to frame start.
            sck_d  = 1'b0;
            ws_d   = 1'b1;
            bit_d  = '0;
            slot_d = '0;
            sh_d   = '0;
        end else begin
            if (tick) begin
                cnt_d = sck_prescaler;
                sck_d = !sck_q;
            end else begin
                cnt_d = cnt_q - PW'(1);
            end
            if (rise && (bit_q < size_eff)) begin
                sh_d = sh_shift[SW-2:0];
            end
            if (fall) begin
                bit_d  = nxt_bit;
                slot_d = nxt_slot;
                ws_d   = ws_nxt;
                if (last_bit) begin
                    sh_d = '0;
                end
            end
        end
    end

    logic          ov_q, ov_d;
    logic [SW-1:0] od_q, od_d;
    logic [CW-1:0] och_q, och_d;
    logic          ovr_q, ovr_d;
    logic          ovr_set;

    always_comb begin
        ov_d    = ov_q;
        od_d    = od_q;
        och_d   = och_q;
        ovr_set = 1'b0;
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        if (new_smp) begin
            if (ov_q && !out_ready) begin
                ovr_set = 1'b1;
            end else begin
                ov_d  = 1'b1;
                od_d  = cap_dat;
                och_d = slot_q;
            end
        end
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sck_q  <= 1'b0;
            ws_q   <= 1'b1;
            bit_q  <= '0;
            slot_q <= '0;
            sh_q   <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            och_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sck_q  <= sck_d;
            ws_q   <= ws_d;
            bit_q  <= bit_d;
            slot_q <= slot_d;
            sh_q   <= sh_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            och_q  <= och_d;
            ovr_q  <= ovr_d;
        end
    end

    assign sck       = sck_q;
    assign ws        = ws_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_ch    = och_q;
    assign overrun   = ovr_q;

`ifdef I2S_TDM_RX_PEAK_EN
    logic [SW-1:0] trk_q, trk_d;
    logic [SW-1:0] peak_q, peak_d;
    logic          pv_q, pv_d;
    logic [SW-1:0] cap_mag;

    // Magnitude is one's-complement so the most negative value still fits in SW bits.
    always_comb begin
        cap_mag = cap_dat[SW-1] ? ~cap_dat : cap_dat;
        trk_d   = trk_q;
        peak_d  = peak_q;
        pv_d    = 1'b0;
        if (!en) begin
            trk_d = '0;
        end else if (fall && last_bit && last_slot) begin
            peak_d = trk_q;
            pv_d   = 1'b1;
            trk_d  = '0;
        end else if (new_smp && (cap_mag > trk_q)) begin
            trk_d = cap_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_q  <= '0;
            peak_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            trk_q  <= trk_d;
            peak_q <= peak_d;
            pv_q   <= pv_d;
        end
    end

    assign peak       = peak_q;
    assign peak_valid = pv_q;
`endif

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Randomised scoreboard bench for i2s_tdm_rx: a frame-level model drives sdi and queues expected samples; a monitor pops on handshake.
`timescale 1ns/1ps
module tb_i2s_tdm_rx;
    localparam int SW  = 32;
    localparam int NCH = 8;
    localparam int PW  = 8;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           rst_n, en, sdi, out_ready, ovr_clr, sign_extend;
    logic [1:0]     mode;
    logic [PW-1:0]  sck_prescaler;
    logic [5:0]     slot_width, sample_size;
    logic [CW:0]    num_slots;
    logic [NCH-1:0] ch_en;
    logic           sck, ws, out_valid, overrun;
    logic [SW-1:0]  out_data;
    logic [CW-1:0]  out_ch;
`ifdef I2S_TDM_RX_PEAK_EN
    logic [SW-1:0]  peak;
    logic           peak_valid;
    longint         peakq[$];
`endif

    typedef struct {
        logic [31:0] d;
        int          ch;
    } exp_t;
    exp_t   expq[$];

    int     checks = 0;
    int     errors = 0;
    bit     rdy_rand = 1'b0;
    bit     use_fixed = 1'b0;
    bit     per_on = 1'b0;
    longint per_exp = 0;
    time    sck_last = 0;
    longint fixed_v [NCH];

    always #5 clk = ~clk;

    i2s_tdm_rx #(.SW(SW), .NCH(NCH), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sck_prescaler(sck_prescaler),
        .slot_width(slot_width), .sample_size(sample_size), .num_slots(num_slots),
        .ch_en(ch_en), .sign_extend(sign_extend), .sck(sck), .ws(ws), .sdi(sdi),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .overrun(overrun), .ovr_clr(ovr_clr)
`ifdef I2S_TDM_RX_PEAK_EN
        , .peak(peak), .peak_valid(peak_valid)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // WS level for frame bit position p, from the framing rules.
    function automatic logic ws_model(input int p, input int fb, input int sw_e, input logic [1:0] m);
        case (m)
            2'b01:   return (p / sw_e) == 1;
            2'b10:   return ((p + 1) % fb) == 0;
            default: return (((p + 1) % fb) / sw_e) == 1;
        endcase
    endfunction

    initial begin : ready_drv
        forever begin
            @(negedge clk);
            if (rdy_rand) out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin : monitor
        logic        hold;
        logic [31:0] hd;
        logic [CW-1:0] hc;
        exp_t        x;
        hold = 1'b0;
        hd   = '0;
        hc   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(hd));
                chk("hold_ch", 64'(out_ch), 64'(hc));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got ch %0d data 0x%0h, expected no sample", out_ch, out_data);
                end else begin
                    x = expq.pop_front();
                    chk("sample_data", 64'(out_data), 64'(x.d));
                    chk("sample_ch", 64'(out_ch), 64'(x.ch));
                end
            end
`ifdef I2S_TDM_RX_PEAK_EN
            if (peak_valid) begin
                if (peakq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_peak: got 0x%0h, expected no pulse", peak);
                end else begin
                    chk("peak", 64'(peak), 64'(peakq.pop_front()));
                end
            end
`endif
            hold = out_valid && !out_ready;
            hd   = out_data;
            hc   = out_ch;
        end
    end

    initial begin : sck_mon
        forever begin
            @(posedge sck);
            if (per_on && sck_last != 0) chk("sck_period", 64'($time - sck_last), 64'(per_exp));
            sck_last = $time;
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: sck/frames did not complete within time limit, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Drives nfr frames from bit 0; abort_k >= 1 drops en at that bit; keep_max limits queued samples (-1 = all).
    task automatic run(input int nfr, input int abort_k, input int keep_max);
        int          sw_e, size_e, n_e, fb, total, pushed, p, s, b, v_in;
        longint      v [NCH];
        longint      e;
        logic [31:0] e32;
        exp_t        x;
`ifdef I2S_TDM_RX_PEAK_EN
        logic [31:0] mag;
        longint      fpk;
        fpk = 0;
`endif
        v_in   = int'(slot_width);
        sw_e   = (v_in < 2) ? 2 : (v_in > SW) ? SW : v_in;
        v_in   = int'(sample_size);
        size_e = (v_in == 0 || v_in > sw_e) ? sw_e : v_in;
        v_in   = int'(num_slots);
        n_e    = (mode != 2'b10) ? 2 : (v_in == 0) ? 1 : (v_in > NCH) ? NCH : v_in;
        fb     = n_e * sw_e;
        total  = nfr * fb;
        pushed = 0;
        per_exp  = 2 * (longint'(sck_prescaler) + 1) * 10;
        sck_last = 0;
        per_on   = 1'b1;
        for (int k = 0; k < total; k++) begin
            p = k % fb;
            s = p / sw_e;
            b = p % sw_e;
            if (k == abort_k) begin
                en = 1'b0;
                break;
            end
            if (p == 0) begin
`ifdef I2S_TDM_RX_PEAK_EN
                fpk = 0;
`endif
                for (int i = 0; i < n_e; i++)
                    v[i] = use_fixed ? fixed_v[i] : (longint'($urandom) & ((64'sd1 <<< sw_e) - 1));
            end
            if (b == size_e - 1 && ch_en[s]) begin
                e = v[s] >>> (sw_e - size_e);
                if (sign_extend && e[size_e-1]) e = e - (64'sd1 <<< size_e);
                e32 = e[31:0];
`ifdef I2S_TDM_RX_PEAK_EN
                mag = e32[31] ? ~e32 : e32;
                if (longint'(mag) > fpk) fpk = longint'(mag);
`endif
                if (keep_max < 0 || pushed < keep_max) begin
                    x.d  = e32;
                    x.ch = s;
                    expq.push_back(x);
                    pushed++;
                end
            end
            sdi = v[s][sw_e-1-b];
            if (k == 0) begin
                @(negedge clk);
                en = 1'b1;
            end
            @(negedge sck);
            #1;
`ifdef I2S_TDM_RX_PEAK_EN
            if (p == fb - 1) peakq.push_back(fpk);
`endif
            chk("ws", 64'(ws), 64'(ws_model((k + 1) % fb, fb, sw_e, mode)));
        end
        en     = 1'b0;
        per_on = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sdi = 1'b0; out_ready = 1'b1; ovr_clr = 1'b0;
        mode = 2'b00; sck_prescaler = 8'd1; slot_width = 6'd32; sample_size = 6'd24;
        num_slots = 4'd2; ch_en = '1; sign_extend = 1'b0;
        for (int i = 0; i < NCH; i++) fixed_v[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 64'(sck), 64'd0);
        chk("rst_ws", 64'(ws), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ch", 64'(out_ch), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        use_fixed  = 1'b1;
        fixed_v[0] = 64'hABCDEF00;
        fixed_v[1] = 64'h12345600;
        run(2, -1, -1);

        sign_extend = 1'b1;
        fixed_v[0]  = 64'h80000000;
        fixed_v[1]  = 64'h7FFFFF55;
        run(1, -1, -1);

        mode = 2'b10; num_slots = 4'd4; slot_width = 6'd16; sample_size = 6'd16;
        ch_en = 8'b0000_1010; sign_extend = 1'b0;
        fixed_v[0] = 64'hAAAA; fixed_v[1] = 64'h1111; fixed_v[2] = 64'h5555; fixed_v[3] = 64'h2222;
        run(2, -1, -1);

        mode = 2'b00; ch_en = '1; use_fixed = 1'b0; out_ready = 1'b0;
        run(1, -1, 1);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        @(negedge clk);
        chk("overrun_clr", 64'(overrun), 64'd0);

        rdy_rand = 1'b1;
        run(1, 16 + 3, -1);
        repeat (2) @(negedge clk);
        chk("abort_ws", 64'(ws), 64'd1);
        chk("abort_sck", 64'(sck), 64'd0);
        repeat (6) @(negedge clk);
        chk("abort_drained", 64'(expq.size()), 64'd0);
        run(1, -1, -1);

`ifdef I2S_TDM_RX_PEAK_EN
        mode = 2'b10; num_slots = 4'd3; sign_extend = 1'b1; use_fixed = 1'b1;
        fixed_v[0] = 64'h0010; fixed_v[1] = 64'hFFF0; fixed_v[2] = 64'h0005;
        run(1, -1, -1);
        use_fixed = 1'b0;
`endif

        for (int t = 0; t < 8; t++) begin
            mode          = 2'($urandom_range(3));
            sck_prescaler = 8'($urandom_range(2));
            slot_width    = 6'($urandom_range(40, 8));
            sample_size   = 6'($urandom_range(40));
            num_slots     = 4'($urandom_range(15));
            ch_en         = 8'($urandom);
            sign_extend   = 1'($urandom_range(1));
            run(2, -1, -1);
        end

        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("queue_empty", 64'(expq.size()), 64'd0);
`ifdef I2S_TDM_RX_PEAK_EN
        chk("peak_queue_empty", 64'(peakq.size()), 64'd0);
`endif
        chk("overrun_final", 64'(overrun), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
